// File: rtl/tft_pwr_seq.sv
// Panel power/enable sequencer: timing generator, then rgb path, then PWM backlight ramp.
// Power-down runs the same steps in reverse order. Frame waits count vsync rising edges.
module tft_pwr_seq #(
    parameter logic [15:0] CLK_FRAMES  = 16'd2,
    parameter logic [15:0] DATA_FRAMES = 16'd1,
    parameter logic [15:0] RAMP_DIV    = 16'd1000,
    parameter logic [31:0] FRAME_TO    = 32'd2000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pwr_on_req,
    input  logic       vsync_in,
    input  logic [7:0] bl_level,
    output logic       timing_en,
    output logic       data_en,
    output logic       tft_bl,
    output logic       pwr_ok,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_CLK_ON   = 3'd1,
        ST_DATA_ON  = 3'd2,
        ST_BL_RAMP  = 3'd3,
        ST_ON       = 3'd4,
        ST_BL_DOWN  = 3'd5,
        ST_DATA_OFF = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_dly_q;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] ramp_cnt_q, ramp_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timing_en_q, timing_en_d;
    logic        data_en_q, data_en_d;
    logic        tft_bl_q, tft_bl_d;
    logic        pwr_ok_q, pwr_ok_d;
    logic        busy_q, busy_d;

    logic        fr_tick_s;
    logic [15:0] wait_n_s;
    logic [15:0] frame_inc_s;
    logic        wait_done_s;
    logic        ramp_tick_s;

    // Frame-wait and ramp-step qualifiers shared by the state logic.
    always_comb begin
        fr_tick_s   = vsync_in & ~vsync_dly_q;
        wait_n_s    = (state_q == ST_CLK_ON) ? CLK_FRAMES : DATA_FRAMES;
        frame_inc_s = frame_cnt_q + {15'd0, fr_tick_s};
        // The watchdog keeps a dead vsync from stalling the sequence.
        wait_done_s = (frame_inc_s >= wait_n_s) || (to_cnt_q >= (FRAME_TO - 32'd1));
        ramp_tick_s = (ramp_cnt_q >= (RAMP_DIV - 16'd1));
    end

    // Next-state and duty computation; a request change wins over wait/ramp completion.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_OFF: begin
                if (pwr_on_req) state_d = ST_CLK_ON;
                else            state_d = ST_OFF;
            end
            ST_CLK_ON: begin
                if (!pwr_on_req)      state_d = ST_OFF;
                else if (wait_done_s) state_d = ST_DATA_ON;
                else                  state_d = ST_CLK_ON;
            end
            ST_DATA_ON: begin
                if (!pwr_on_req)      state_d = ST_DATA_OFF;
                else if (wait_done_s) state_d = ST_BL_RAMP;
                else                  state_d = ST_DATA_ON;
            end
            ST_BL_RAMP: begin
                if (!pwr_on_req) begin
                    state_d = ST_BL_DOWN;
                end else if (duty_q == bl_level) begin
                    state_d = ST_ON;
                end else if (ramp_tick_s) begin
                    // Step toward the target so a resumed ramp above bl_level still converges.
                    duty_d = (duty_q < bl_level) ? (duty_q + 8'd1) : (duty_q - 8'd1);
                end else begin
                    state_d = ST_BL_RAMP;
                end
            end
            ST_ON: begin
                if (!pwr_on_req) begin
                    state_d = ST_BL_DOWN;
                end else if (ramp_tick_s && (duty_q != bl_level)) begin
                    duty_d = (duty_q < bl_level) ? (duty_q + 8'd1) : (duty_q - 8'd1);
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_BL_DOWN: begin
                if (pwr_on_req)         state_d = ST_BL_RAMP;
                else if (duty_q == 8'd0) state_d = ST_DATA_OFF;
                else if (ramp_tick_s)   duty_d  = duty_q - 8'd1;
                else                    state_d = ST_BL_DOWN;
            end
            ST_DATA_OFF: begin
                if (wait_done_s) state_d = ST_OFF;
                else             state_d = ST_DATA_OFF;
            end
            default: begin
                state_d = ST_OFF;
                duty_d  = 8'd0;
            end
        endcase
    end

    // Wait and ramp counters restart whenever the state changes.
    always_comb begin
        if (state_d != state_q) begin
            frame_cnt_d = 16'd0;
            to_cnt_d    = 32'd0;
            ramp_cnt_d  = 16'd0;
        end else begin
            frame_cnt_d = frame_inc_s;
            to_cnt_d    = fr_tick_s ? 32'd0 : (to_cnt_q + 32'd1);
            ramp_cnt_d  = ramp_tick_s ? 16'd0 : (ramp_cnt_q + 16'd1);
        end
    end

    // Output decode from the current state, so enables lag the state by one cycle.
    always_comb begin
        timing_en_d = 1'b1;
        data_en_d   = 1'b0;
        pwr_ok_d    = 1'b0;
        busy_d      = 1'b1;
        case (state_q)
            ST_OFF:      begin timing_en_d = 1'b0; busy_d = 1'b0; end
            ST_CLK_ON:   data_en_d = 1'b0;
            ST_DATA_ON:  data_en_d = 1'b1;
            ST_BL_RAMP:  data_en_d = 1'b1;
            ST_ON:       begin data_en_d = 1'b1; pwr_ok_d = 1'b1; busy_d = 1'b0; end
            ST_BL_DOWN:  data_en_d = 1'b1;
            ST_DATA_OFF: data_en_d = 1'b0;
            default:     begin timing_en_d = 1'b0; busy_d = 1'b0; end
        endcase
        pwm_cnt_d = timing_en_q ? (pwm_cnt_q + 8'd1) : 8'd0;
        tft_bl_d  = (duty_q > pwm_cnt_q);
    end

    // State, counter and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_OFF;
            vsync_dly_q <= 1'b1;
            duty_q      <= 8'd0;
            pwm_cnt_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
            ramp_cnt_q  <= 16'd0;
            to_cnt_q    <= 32'd0;
            timing_en_q <= 1'b0;
            data_en_q   <= 1'b0;
            tft_bl_q    <= 1'b0;
            pwr_ok_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_dly_q <= vsync_in;
            duty_q      <= duty_d;
            pwm_cnt_q   <= pwm_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ramp_cnt_q  <= ramp_cnt_d;
            to_cnt_q    <= to_cnt_d;
            timing_en_q <= timing_en_d;
            data_en_q   <= data_en_d;
            tft_bl_q    <= tft_bl_d;
            pwr_ok_q    <= pwr_ok_d;
            busy_q      <= busy_d;
        end
    end

    assign timing_en = timing_en_q;
    assign data_en   = data_en_q;
    assign tft_bl    = tft_bl_q;
    assign pwr_ok    = pwr_ok_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tft_pwr_seq.sv
// Directed bench for tft_pwr_seq: one instance with live vsync, one with vsync stuck low.
module tb_tft_pwr_seq;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       req_a, vsync_a, req_b, vsync_b;
    logic [7:0] bl_a, bl_b;
    logic       ten_a, den_a, bl_out_a, ok_a, busy_a;
    logic       ten_b, den_b, bl_out_b, ok_b, busy_b;
    int         n_cmp;
    int         n_err;

    tft_pwr_seq #(
        .CLK_FRAMES(16'd2), .DATA_FRAMES(16'd1), .RAMP_DIV(16'd4), .FRAME_TO(32'd1000)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwr_on_req(req_a), .vsync_in(vsync_a),
        .bl_level(bl_a), .timing_en(ten_a), .data_en(den_a), .tft_bl(bl_out_a),
        .pwr_ok(ok_a), .busy(busy_a)
    );

    tft_pwr_seq #(
        .CLK_FRAMES(16'd2), .DATA_FRAMES(16'd1), .RAMP_DIV(16'd4), .FRAME_TO(32'd50)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwr_on_req(req_b), .vsync_in(vsync_b),
        .bl_level(bl_b), .timing_en(ten_b), .data_en(den_b), .tft_bl(bl_out_b),
        .pwr_ok(ok_b), .busy(busy_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Three vsync pulses 100 cycles apart, then bounded wait for pwr_ok.
    task automatic bring_up();
        int waited;
        req_a = 1'b1;
        repeat (2) cyc();
        for (int k = 0; k < 3; k++) begin
            vsync_a = 1'b1;
            repeat (5) cyc();
            vsync_a = 1'b0;
            if (k < 2) repeat (95) cyc();
        end
        waited = 0;
        while (ok_a !== 1'b1 && waited < 100) begin
            cyc();
            waited++;
        end
        n_cmp = n_cmp + 1;
        if (ok_a !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL bring_up_pwr_ok: got %b expected 1 after %0d cycles", ok_a, waited);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        req_a = 1'b0; vsync_a = 1'b0; bl_a = 8'd8;
        req_b = 1'b0; vsync_b = 1'b0; bl_b = 8'd8;
        repeat (3) cyc();
        chk("rst_timing_en", {31'd0, ten_a}, 32'd0);
        chk("rst_data_en", {31'd0, den_a}, 32'd0);
        chk("rst_tft_bl", {31'd0, bl_out_a}, 32'd0);
        chk("rst_pwr_ok", {31'd0, ok_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_b_outs", {27'd0, ten_b, den_b, bl_out_b, ok_b, busy_b}, 32'd0);
        sys_rst_n = 1'b1;
        repeat (3) cyc();
        chk("idle_off_timing_en", {31'd0, ten_a}, 32'd0);
    endtask

    task automatic test_power_up();
        req_a = 1'b1;
        cyc();
        chk("pu_timing_en_t1", {31'd0, ten_a}, 32'd0);
        cyc();
        chk("pu_timing_en_t2", {31'd0, ten_a}, 32'd1);
        chk("pu_busy_t2", {31'd0, busy_a}, 32'd1);
        repeat (20) cyc();
        vsync_a = 1'b1;
        repeat (5) cyc();
        vsync_a = 1'b0;
        repeat (95) cyc();
        chk("pu_data_en_after_1_frame", {31'd0, den_a}, 32'd0);
        vsync_a = 1'b1;
        cyc();
        chk("pu_data_en_at_2nd_rise", {31'd0, den_a}, 32'd0);
        cyc();
        chk("pu_data_en_rise", {31'd0, den_a}, 32'd1);
        repeat (3) cyc();
        vsync_a = 1'b0;
        repeat (95) cyc();
        vsync_a = 1'b1;
        cyc();
        chk("pu_ramp_start_duty", {24'd0, dut_a.duty_q}, 32'd0);
        repeat (16) cyc();
        chk("pu_ramp_duty_16", {24'd0, dut_a.duty_q}, 32'd4);
        repeat (16) cyc();
        chk("pu_ramp_duty_32", {24'd0, dut_a.duty_q}, 32'd8);
        chk("pu_pwr_ok_early", {31'd0, ok_a}, 32'd0);
        vsync_a = 1'b0;
        repeat (2) cyc();
        chk("pu_pwr_ok", {31'd0, ok_a}, 32'd1);
        chk("pu_busy_done", {31'd0, busy_a}, 32'd0);
    endtask

    task automatic test_pwm();
        int hi;
        bl_a = 8'd128;
        repeat (600) cyc();
        chk("pwm_duty_128", {24'd0, dut_a.duty_q}, 32'd128);
        hi = 0;
        repeat (256) begin cyc(); hi += int'(bl_out_a); end
        chk("pwm_high_128", hi, 32'd128);
        bl_a = 8'd0;
        repeat (600) cyc();
        hi = 0;
        repeat (256) begin cyc(); hi += int'(bl_out_a); end
        chk("pwm_high_0", hi, 32'd0);
        chk("pwm_still_on", {31'd0, ok_a}, 32'd1);
        bl_a = 8'd8;
        repeat (100) cyc();
        hi = 0;
        repeat (256) begin cyc(); hi += int'(bl_out_a); end
        chk("pwm_high_8", hi, 32'd8);
    endtask

    task automatic test_power_down();
        req_a = 1'b0;
        cyc();
        cyc();
        chk("pd_pwr_ok_drop", {31'd0, ok_a}, 32'd0);
        repeat (31) cyc();
        chk("pd_duty_zero", {24'd0, dut_a.duty_q}, 32'd0);
        chk("pd_data_en_held", {31'd0, den_a}, 32'd1);
        repeat (2) cyc();
        chk("pd_data_en_fall", {31'd0, den_a}, 32'd0);
        chk("pd_timing_en_held", {31'd0, ten_a}, 32'd1);
        repeat (20) cyc();
        vsync_a = 1'b1;
        cyc();
        chk("pd_timing_en_at_rise", {31'd0, ten_a}, 32'd1);
        cyc();
        chk("pd_timing_en_fall", {31'd0, ten_a}, 32'd0);
        chk("pd_busy_off", {31'd0, busy_a}, 32'd0);
        vsync_a = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic test_reramp();
        bring_up();
        req_a = 1'b0;
        repeat (13) cyc();
        chk("rr_duty_down_5", {24'd0, dut_a.duty_q}, 32'd5);
        req_a = 1'b1;
        cyc();
        chk("rr_duty_hold_5", {24'd0, dut_a.duty_q}, 32'd5);
        repeat (4) cyc();
        chk("rr_duty_6", {24'd0, dut_a.duty_q}, 32'd6);
        repeat (8) cyc();
        chk("rr_duty_8", {24'd0, dut_a.duty_q}, 32'd8);
        repeat (2) cyc();
        chk("rr_pwr_ok", {31'd0, ok_a}, 32'd1);
    endtask

    task automatic test_timeout();
        req_b = 1'b1;
        cyc();
        repeat (50) cyc();
        chk("to_data_en_before", {31'd0, den_b}, 32'd0);
        cyc();
        chk("to_data_en_after_50", {31'd0, den_b}, 32'd1);
        repeat (82) cyc();
        chk("to_pwr_ok_early", {31'd0, ok_b}, 32'd0);
        cyc();
        chk("to_pwr_ok", {31'd0, ok_b}, 32'd1);
        chk("to_duty", {24'd0, dut_b.duty_q}, 32'd8);
    endtask

    task automatic test_reset_mid();
        req_a = 1'b0;
        repeat (21) cyc();
        req_a = 1'b1;
        cyc();
        chk("rm_duty_3", {24'd0, dut_a.duty_q}, 32'd3);
        chk("rm_timing_en_pre", {31'd0, ten_a}, 32'd1);
        chk("rm_data_en_pre", {31'd0, den_a}, 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rm_timing_en_async", {31'd0, ten_a}, 32'd0);
        chk("rm_data_en_async", {31'd0, den_a}, 32'd0);
        chk("rm_tft_bl_async", {31'd0, bl_out_a}, 32'd0);
        chk("rm_duty_async", {24'd0, dut_a.duty_q}, 32'd0);
        repeat (2) cyc();
        sys_rst_n = 1'b1;
        cyc();
        bring_up();
        chk("rm_restart_duty", {24'd0, dut_a.duty_q}, 32'd8);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_power_up();
        test_pwm();
        test_power_down();
        test_reramp();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
